// File: rtl/cpu_core_mc.sv
// cpu_core_mc: multi-cycle RV32I-subset core with an external fetch handshake.
// Executes OP-IMM, LUI, AUIPC, JAL, JALR and EBREAK; stops on ebreak,
// illegal instructions or misaligned jump targets.
// Optional commit trace outputs are built when COMMIT_TRACE_EN is defined.
module cpu_core_mc #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          NREGS    = 32,
    parameter int          RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rest,
    output logic                inst_req,
    output logic [31:0]         inst_addr,
    input  logic                inst_valid,
    input  logic [31:0]         inst,
    output logic                halt,
    output logic                trap,
    output logic [31:0]         exit_code,
    output logic [RETIRE_W-1:0] retired
`ifdef COMMIT_TRACE_EN
    ,
    output logic                commit_valid,
    output logic [31:0]         commit_pc,
    output logic [31:0]         commit_inst
`endif
);

    localparam int             AW       = $clog2(NREGS);
    localparam logic [AW-1:0]  A0_IDX   = AW'(10);
    localparam logic [6:0]     OP_IMM   = 7'b0010011;
    localparam logic [6:0]     OP_LUI   = 7'b0110111;
    localparam logic [6:0]     OP_AUIPC = 7'b0010111;
    localparam logic [6:0]     OP_JAL   = 7'b1101111;
    localparam logic [6:0]     OP_JALR  = 7'b1100111;
    localparam logic [6:0]     OP_SYS   = 7'b1110011;
    localparam logic [31:0]    EBREAK_W = 32'h0010_0073;

    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

    state_t             state, state_nxt;
    logic               req_nxt;
    logic [31:0]        pc;
    logic [31:0]        ir;
    logic [31:0]        regs [NREGS];

    logic [6:0]         opcode;
    logic [4:0]         rd, rs1, shamt;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic signed [31:0] imm_i, imm_j;
    logic [31:0]        imm_u;
    logic signed [31:0] rs1_val;
    logic [31:0]        a0_val;

    logic signed [31:0] exe_res;
    logic [31:0]        exe_tgt;
    logic               exe_wr, exe_jump, exe_ill, exe_brk, exe_rs1, exe_mis;
    logic               exe_stop, exe_trap;

    assign opcode    = ir[6:0];
    assign rd        = ir[11:7];
    assign funct3    = ir[14:12];
    assign rs1       = ir[19:15];
    assign shamt     = ir[24:20];
    assign funct7    = ir[31:25];
    assign imm_i     = {{20{ir[31]}}, ir[31:20]};
    assign imm_u     = {ir[31:12], 12'b0};
    assign imm_j     = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    assign rs1_val   = (rs1 == 5'd0) ? '0 : regs[rs1[AW-1:0]];
    assign a0_val    = regs[A0_IDX];
    assign inst_addr = pc;

    // Decode and execute the latched instruction word.
    always_comb begin
        exe_res  = '0;
        exe_tgt  = pc + 32'd4;
        exe_wr   = 1'b0;
        exe_jump = 1'b0;
        exe_ill  = 1'b0;
        exe_brk  = 1'b0;
        exe_rs1  = 1'b0;
        case (opcode)
            OP_IMM: begin
                exe_wr  = 1'b1;
                exe_rs1 = 1'b1;
                case (funct3)
                    3'b000: exe_res = rs1_val + imm_i;
                    3'b010: exe_res = {31'b0, (rs1_val < imm_i)};
                    3'b011: exe_res = {31'b0, ($unsigned(rs1_val) < $unsigned(imm_i))};
                    3'b100: exe_res = rs1_val ^ imm_i;
                    3'b110: exe_res = rs1_val | imm_i;
                    3'b111: exe_res = rs1_val & imm_i;
                    3'b001: begin
                        exe_res = rs1_val << shamt;
                        exe_ill = (funct7 != 7'b0);
                    end
                    3'b101: begin
                        if (funct7 == 7'b0)
                            exe_res = $unsigned(rs1_val) >> shamt;
                        else if (funct7 == 7'b0100000)
                            exe_res = rs1_val >>> shamt;
                        else
                            exe_ill = 1'b1;
                    end
                endcase
            end
            OP_LUI: begin
                exe_wr  = 1'b1;
                exe_res = imm_u;
            end
            OP_AUIPC: begin
                exe_wr  = 1'b1;
                exe_res = pc + imm_u;
            end
            OP_JAL: begin
                exe_wr   = 1'b1;
                exe_jump = 1'b1;
                exe_res  = pc + 32'd4;
                exe_tgt  = pc + imm_j;
            end
            OP_JALR: begin
                exe_wr   = 1'b1;
                exe_jump = 1'b1;
                exe_rs1  = 1'b1;
                exe_res  = pc + 32'd4;
                exe_tgt  = (rs1_val + imm_i) & ~32'd1;
                exe_ill  = (funct3 != 3'b000);
            end
            OP_SYS: begin
                exe_brk = (ir == EBREAK_W);
                exe_ill = (ir != EBREAK_W);
            end
            default: exe_ill = 1'b1;
        endcase
        // RV32E: register indices 16..31 do not exist
        if (NREGS == 16 && ((exe_wr && rd[4]) || (exe_rs1 && rs1[4])))
            exe_ill = 1'b1;
        exe_mis  = exe_jump && (exe_tgt[1:0] != 2'b00);
        exe_stop = exe_ill || exe_mis || exe_brk;
        exe_trap = exe_ill || exe_mis;
    end

    // Next-state and registered-request logic for the FETCH/EXEC/HALT sequencer.
    always_comb begin
        state_nxt = state;
        req_nxt   = 1'b0;
        case (state)
            FETCH: begin
                if (inst_req && inst_valid)
                    state_nxt = EXEC;
                else
                    req_nxt = 1'b1;
            end
            EXEC:    state_nxt = exe_stop ? HALT : FETCH;
            HALT:    state_nxt = HALT;
            default: state_nxt = FETCH;
        endcase
    end

    // Control state: sequencer, pc, stop flags and retire counter.
    always_ff @(posedge clk) begin
        if (rest) begin
            state     <= FETCH;
            inst_req  <= 1'b0;
            pc        <= RESET_PC;
            halt      <= 1'b0;
            trap      <= 1'b0;
            exit_code <= '0;
            retired   <= '0;
        end else begin
            state    <= state_nxt;
            inst_req <= req_nxt;
            if (state == EXEC) begin
                if (exe_stop) begin
                    halt      <= 1'b1;
                    trap      <= exe_trap;
                    exit_code <= a0_val;
                end else begin
                    pc      <= exe_jump ? exe_tgt : pc + 32'd4;
                    retired <= retired + 1'b1;
                end
            end
        end
    end

    // Instruction register: captures the word on an accepted fetch.
    always_ff @(posedge clk) begin
        if (state == FETCH && inst_req && inst_valid)
            ir <= inst;
    end

    // Register file write port; x0 is never written and reads as zero.
    always_ff @(posedge clk) begin
        if (!rest && state == EXEC && !exe_stop && exe_wr && rd != 5'd0)
            regs[rd[AW-1:0]] <= exe_res;
    end

`ifdef COMMIT_TRACE_EN
    assign commit_valid = (state == EXEC) && !exe_stop;
    assign commit_pc    = commit_valid ? pc : '0;
    assign commit_inst  = commit_valid ? ir : '0;
`endif

endmodule
